// File: rtl/decipher.sv
// Iterative AES inverse cipher (128/192/256-bit keys), one round per clock.
// Round keys are read from an external key SRAM with a 1-cycle read latency, walked from Nr down to 0.
`ifndef BLK_S
`define BLK_S 128
`endif
`ifndef ROUND_KEY_BITS
`define ROUND_KEY_BITS 128
`endif
`ifndef Nb
`define Nb 4
`endif
`ifndef Nr_128
`define Nr_128 10
`endif
`ifndef Nr_256
`define Nr_256 14
`endif

module decipher (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [`Nb-1:0]             rounds_total,
  input  logic [`BLK_S-1:0]          ciphertext,
  input  logic [`ROUND_KEY_BITS-1:0] key,
  output logic [`BLK_S-1:0]          plaintext,
  output logic [`Nb-1:0]             round_key_no,
  output logic                       en_o
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [2:0] {IDLE, FETCH, INIT, ROUND, FINAL} state_e;

  state_e                 fsm_q;
  logic [`BLK_S-1:0]      state_q;
  logic [`BLK_S-1:0]      plaintext_q;
  logic [`Nb-1:0]         nr_q;
  logic [`Nb-1:0]         rkn_q;
  logic                   done_q;

  logic [`BLK_S-1:0]      sr_sb;
  logic [`BLK_S-1:0]      ark;
  logic [`BLK_S-1:0]      mixed;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte n of the block sits at bits [127-8n -: 8]; row = n%4, column = n/4.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        o[127 - 8*(r + 4*c) -: 8] = INV_SBOX[s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a2 [4];
    logic [7:0]   a4 [4];
    logic [7:0]   a8 [4];
    logic [7:0]   a  [4];
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        a[r]  = s[127 - 8*(r + 4*c) -: 8];
        a2[r] = xt(a[r]);
        a4[r] = xt(a2[r]);
        a8[r] = xt(a4[r]);
      end
      for (int unsigned r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] =
            (a8[r] ^ a4[r] ^ a2[r])                             // 0e
          ^ (a8[(r+1)%4] ^ a2[(r+1)%4] ^ a[(r+1)%4])            // 0b
          ^ (a8[(r+2)%4] ^ a4[(r+2)%4] ^ a[(r+2)%4])            // 0d
          ^ (a8[(r+3)%4] ^ a[(r+3)%4]);                         // 09
    end
    return o;
  endfunction

  always_comb begin
    sr_sb = inv_shift_sub(state_q);
    ark   = sr_sb ^ key;
    mixed = inv_mix(ark);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      plaintext_q <= '0;
      nr_q        <= '0;
      rkn_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: if (en) begin
          state_q <= ciphertext;
          nr_q    <= rounds_total;
          rkn_q   <= rounds_total;
          fsm_q   <= FETCH;
        end
        FETCH: begin
          rkn_q <= nr_q - 1'b1;
          fsm_q <= INIT;
        end
        INIT: begin
          state_q <= state_q ^ key;
          rkn_q   <= rkn_q - 1'b1;
          fsm_q   <= ROUND;
        end
        // The SRAM lags by one cycle, so rkn_q==0 here means K[1] is on key.
        ROUND: begin
          state_q <= mixed;
          if (rkn_q == '0) fsm_q <= FINAL;
          else             rkn_q <= rkn_q - 1'b1;
        end
        FINAL: begin
          plaintext_q <= ark;
          done_q      <= 1'b1;
          fsm_q       <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign plaintext    = plaintext_q;
  assign round_key_no = rkn_q;
  assign en_o         = done_q;

endmodule

// File: tb/tb_decipher.sv
// Self-checking bench for decipher: FIPS-197 KATs, back-to-back, busy/abort,
// and random blocks checked against a behavioural AES model with a key SRAM model.
module tb_decipher;

  logic         clk;
  logic         reset;
  logic         en;
  logic [3:0]   rounds_total;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic [3:0]   round_key_no;
  logic         en_o;

  int total = 0;
  int bad   = 0;

  logic [127:0] rk_mem [16];
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] pt_model;

  decipher dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .rounds_total (rounds_total),
    .ciphertext   (ciphertext),
    .key          (key),
    .plaintext    (plaintext),
    .round_key_no (round_key_no),
    .en_o         (en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key SRAM: registered read, one cycle behind the address.
  always @(posedge clk) key <= rk_mem[round_key_no];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // FIPS-197 key expansion into the SRAM model; nk = 4, 6 or 8 words.
  function automatic void expand(input logic [255:0] k, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4*(nk+7); i++) begin
      if (i < nk) w[i] = k[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nk+6; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
    logic [7:0]   cf [4];
    logic [127:0] o;
    logic [7:0]   acc;
    if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
    else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(cf[(j - r + 4) % 4], s[127-8*(j+4*c) -: 8]);
        o[127-8*(r+4*c) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt, input int nr);
    logic [127:0] s;
    logic [127:0] t;
    s = pt ^ rk_mem[0];
    for (int r = 1; r <= nr; r++) begin
      for (int n = 0; n < 16; n++) t[127-8*n -: 8] = sbox[s[127-8*n -: 8]];
      for (int n = 0; n < 16; n++) s[127-8*n -: 8] = t[127-8*((n%4) + 4*(((n/4) + (n%4)) % 4)) -: 8];
      if (r != nr) s = mix(s, 1'b0);
      s = s ^ rk_mem[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] dec(input logic [127:0] ct, input int nr);
    logic [127:0] s;
    logic [127:0] t;
    s = ct ^ rk_mem[nr];
    for (int r = nr-1; r >= 0; r--) begin
      for (int n = 0; n < 16; n++) t[127-8*n -: 8] = s[127-8*((n%4) + 4*(((n/4) + 4 - (n%4)) % 4)) -: 8];
      for (int n = 0; n < 16; n++) s[127-8*n -: 8] = isbox[t[127-8*n -: 8]];
      s = s ^ rk_mem[r];
      if (r != 0) s = mix(s, 1'b1);
    end
    return s;
  endfunction

  // Called at a negedge while idle; returns at the negedge after the sampling edge.
  task automatic launch(input logic [127:0] ct, input logic [3:0] nr);
    en = 1'b1;
    ciphertext = ct;
    rounds_total = nr;
    @(negedge clk);
    en = 1'b0;
    check("rkn_start", 128'(round_key_no), 128'(nr));
    check("en_o_low", 128'(en_o), 128'(0));
  endtask

  task automatic wait_done(input int nr, input logic [127:0] exp, input string tag,
                           input bit disturb, input bit chain);
    bit seen;
    seen = 1'b0;
    for (int k = 1; k <= nr + 6 && !seen; k++) begin
      if (disturb) begin
        en = (k <= 4);
        ciphertext = {$urandom, $urandom, $urandom, $urandom};
        rounds_total = 4'd14;
      end
      @(negedge clk);
      if (en_o) begin
        seen = 1'b1;
        check({tag, "_lat"}, 128'(k), 128'(nr + 2));
        check({tag, "_pt"}, plaintext, exp);
        pt_model = exp;
      end else begin
        check({tag, "_hold"}, plaintext, pt_model);
      end
      if (k <= nr + 2) check({tag, "_rkn"}, 128'(round_key_no), 128'(nr > k ? nr - k : 0));
    end
    if (disturb) en = 1'b0;
    check({tag, "_done"}, 128'(seen), 128'(1));
    if (seen && !chain) begin
      @(negedge clk);
      check({tag, "_pulse"}, 128'(en_o), 128'(0));
      check({tag, "_keep"}, plaintext, pt_model);
    end
  endtask

  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] KAT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [255:0] kat_key;
    logic [255:0] rkey;
    logic [127:0] rpt;
    logic [127:0] rct;
    int           nk;
    int           cnt;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      s = inv ^ rotl1(inv) ^ rotl1(rotl1(inv)) ^ rotl1(rotl1(rotl1(inv)))
        ^ rotl1(rotl1(rotl1(rotl1(inv)))) ^ 8'h63;
      sbox[x] = s;
      isbox[s] = x[7:0];
    end
    for (int i = 0; i < 16; i++) rk_mem[i] = '0;
    for (int i = 0; i < 32; i++) kat_key[255-8*i -: 8] = i[7:0];

    reset = 1'b1; en = 1'b0; rounds_total = 4'd10; ciphertext = '0;
    pt_model = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_pt", plaintext, 128'(0));
    check("rst_rkn", 128'(round_key_no), 128'(0));
    check("rst_en_o", 128'(en_o), 128'(0));

    expand(kat_key, 4);
    launch(KAT_C1, 4'd10);
    wait_done(10, KAT_PT, "c1", 1'b0, 1'b0);
    expand(kat_key, 8);
    launch(KAT_C3, 4'd14);
    wait_done(14, KAT_PT, "c3", 1'b0, 1'b0);
    expand(kat_key, 6);
    launch(KAT_C2, 4'd12);
    wait_done(12, KAT_PT, "c2", 1'b0, 1'b0);

    // Back-to-back: second start in the en_o cycle; the AES-256 schedule's first 4 words match C.1's key,
    // but its round keys differ, so the SRAM is switched once the first run has fetched its last key.
    expand(kat_key, 4);
    launch(128'h0, 4'd10);
    wait_done(10, dec(128'h0, 10), "b2b_pre", 1'b0, 1'b0);
    begin
      logic [127:0] exp_b2b;
      expand(kat_key, 8);
      rct = enc(KAT_PT ^ 128'h1, 14);
      exp_b2b = KAT_PT ^ 128'h1;
      launch(KAT_C3, 4'd14);
      wait_done(14, KAT_PT, "b2b_a", 1'b0, 1'b1);
      launch(rct, 4'd14);
      wait_done(14, exp_b2b, "b2b_b", 1'b0, 1'b0);
    end

    expand(kat_key, 4);
    launch(KAT_C1, 4'd10);
    wait_done(10, KAT_PT, "busy", 1'b1, 1'b0);

    launch(KAT_C1 ^ 128'h55, 4'd10);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_pt", plaintext, 128'(0));
    check("abort_rkn", 128'(round_key_no), 128'(0));
    check("abort_en_o", 128'(en_o), 128'(0));
    pt_model = '0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (en_o) cnt++;
    end
    check("abort_no_done", 128'(cnt), 128'(0));
    launch(KAT_C1, 4'd10);
    wait_done(10, KAT_PT, "c1_again", 1'b0, 1'b0);

    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 2))
        0:       nk = 4;
        1:       nk = 6;
        default: nk = 8;
      endcase
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rpt  = {$urandom, $urandom, $urandom, $urandom};
      expand(rkey, nk);
      rct = enc(rpt, nk + 6);
      launch(rct, 4'(nk + 6));
      wait_done(nk + 6, rpt, "loop", 1'b0, 1'b0);
    end

    for (int i = 0; i < 20; i++) begin
      nk = 4 + 2 * int'($urandom_range(0, 2));
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rct  = {$urandom, $urandom, $urandom, $urandom};
      expand(rkey, nk);
      launch(rct, 4'(nk + 6));
      wait_done(nk + 6, dec(rct, nk + 6), "rand", 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
